// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display controller:
// register layout, segment type and the hex-to-segment lookup.
package seven_seg_pkg;

    // DIGITn words start at DIGIT_BASE; CTRL sits directly after the last digit
    localparam int DIGIT_BASE      = 0;

    localparam int DIGIT_VAL_LSB   = 0;
    localparam int DIGIT_VAL_W     = 4;
    localparam int DIGIT_DP_BIT    = 4;
    localparam int DIGIT_BLANK_BIT = 5;
    localparam int DIGIT_W         = 6;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_BRIGHT_LSB = 1;
    localparam int CTRL_BRIGHT_W   = 4;

    typedef logic [6:0] seg_t;

    localparam seg_t                     SEG_OFF      = 7'h7F;
    localparam logic [CTRL_BRIGHT_W-1:0] BRIGHT_RESET = 4'hF;

    // Cathode pattern {g,f,e,d,c,b,a}, active-low
    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        seg_t seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational digit encoder: hex value and decimal-point enable to
// active-low cathode and dp levels.
module seven_seg_encoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp_en,
    output seg_t       seg,
    output logic       dp_n
);

    assign seg  = hex_to_seg(hex);
    assign dp_n = ~dp_en;

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// Memory-mapped, time-multiplexed seven-segment display controller with
// per-digit value/dp/blank registers and PWM brightness on the anodes.
module seven_seg_display_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 4096,
    parameter int ADDR_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [31:0]           wr_data_i,
    output logic [31:0]           rd_data_o,
    output seg_t                  seg_o,
    output logic                  dp_o,
    output logic [NUM_DIGITS-1:0] an_o
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(DIGIT_BASE + NUM_DIGITS);

    logic [DIGIT_W-1:0]       digit_regs [NUM_DIGITS];
    logic                     ctrl_enable;
    logic [CTRL_BRIGHT_W-1:0] ctrl_bright;

    logic [PW-1:0]            prescaler;
    logic [IW-1:0]            digit_idx;
    logic [3:0]               ph;

    logic [31:0]              rd_mux;
    logic [DIGIT_W-1:0]       cur_digit;
    seg_t                     enc_seg;
    logic                     enc_dp_n;
    logic                     anode_on;
    logic [NUM_DIGITS-1:0]    an_next;

    logic                     unused_wr_bits;
    assign unused_wr_bits = ^wr_data_i[31:DIGIT_W];

    // Bus: wr_en_i/rd_en_i are single-cycle strobes with no back-pressure;
    // writes commit on the strobed edge, reads present data one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_regs[i] <= '0;
            end
            ctrl_enable <= 1'b0;
            ctrl_bright <= BRIGHT_RESET;
        end else if (wr_en_i) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (addr_i == ADDR_W'(DIGIT_BASE + i)) begin
                    digit_regs[i] <= wr_data_i[DIGIT_W-1:0];
                end
            end
            if (addr_i == CTRL_ADDR) begin
                ctrl_enable <= wr_data_i[CTRL_EN_BIT];
                ctrl_bright <= wr_data_i[CTRL_BRIGHT_LSB +: CTRL_BRIGHT_W];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (addr_i == ADDR_W'(DIGIT_BASE + i)) begin
                rd_mux = 32'(digit_regs[i]);
            end
        end
        if (addr_i == CTRL_ADDR) begin
            rd_mux = 32'({ctrl_bright, ctrl_enable});
        end
    end

    // Sampled before any same-edge write lands, so a colliding read sees the old word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= rd_mux;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else if (!ctrl_enable) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else if (&prescaler) begin
            prescaler <= '0;
            digit_idx <= (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign ph = prescaler[PW-1 -: 4];

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IW'(i)) begin
                cur_digit = digit_regs[i];
            end
        end
    end

    seven_seg_encoder u_encoder (
        .hex   (cur_digit[DIGIT_VAL_LSB +: DIGIT_VAL_W]),
        .dp_en (cur_digit[DIGIT_DP_BIT]),
        .seg   (enc_seg),
        .dp_n  (enc_dp_n)
    );

    assign anode_on = ctrl_enable && !cur_digit[DIGIT_BLANK_BIT] && (ph <= ctrl_bright);

    always_comb begin
        an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (anode_on && (digit_idx == IW'(i))) begin
                an_next[i] = 1'b0;
            end
        end
    end

    // Cathodes are forced off whenever the anode is off to avoid ghosting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_o <= SEG_OFF;
            dp_o  <= 1'b1;
            an_o  <= '1;
        end else begin
            seg_o <= anode_on ? enc_seg : SEG_OFF;
            dp_o  <= anode_on ? enc_dp_n : 1'b1;
            an_o  <= an_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed self-checking bench for seven_seg_display_ctrl with 8 digits and
// a 16-cycle refresh slot.
module tb_seven_seg_display_ctrl;

    localparam int ND     = 8;
    localparam int RD     = 16;
    localparam int AW     = 4;
    localparam logic [AW-1:0] CTRL_A = 4'd8;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];

    logic [6:0] seg_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_display_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .ADDR_W      (AW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .rd_en_i   (rd_en),
        .addr_i    (addr),
        .wr_data_i (wr_data),
        .rd_data_o (rd_data),
        .seg_o     (seg),
        .dp_o      (dp),
        .an_o      (an)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
    endtask

    // Disable then enable so the scan starts at digit 0, prescaler 0
    task automatic restart_scan(input logic [31:0] c);
        bus_write(CTRL_A, 32'h0);
        bus_write(CTRL_A, c);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        restart_scan(32'h1F);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (an !== 8'hFD) begin
            n_err++; $display("FAIL pre_reset_an got %h exp %h", an, 8'hFD);
        end
        bus_read(CTRL_A, d);
        n_cmp++;
        if (d !== 32'h1F) begin
            n_err++; $display("FAIL pre_reset_ctrl got %h exp %h", d, 32'h1F);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (an !== 8'hFF) begin
            n_err++; $display("FAIL reset_an got %h exp %h", an, 8'hFF);
        end
        n_cmp++;
        if (seg !== 7'h7F) begin
            n_err++; $display("FAIL reset_seg got %h exp %h", seg, 7'h7F);
        end
        n_cmp++;
        if (dp !== 1'b1) begin
            n_err++; $display("FAIL reset_dp got %b exp 1", dp);
        end
        n_cmp++;
        if (rd_data !== 32'h0) begin
            n_err++; $display("FAIL reset_rd_data got %h exp 0", rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_read(CTRL_A, d);
        n_cmp++;
        if (d !== 32'h1E) begin
            n_err++; $display("FAIL reset_ctrl_read got %h exp %h", d, 32'h1E);
        end
        bus_read(4'd0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL reset_digit0_read got %h exp 0", d);
        end
    endtask

    task automatic test_scan();
        int slot;
        logic [7:0] exp_an;
        for (int i = 0; i < ND; i++) bus_write(AW'(i), 32'(i));
        restart_scan(32'h1F);
        for (int k = 1; k <= 144; k++) begin
            @(negedge clk);
            slot = ((k - 1) / RD) % ND;
            exp_an = ~(8'h01 << slot);
            n_cmp++;
            if (an !== exp_an) begin
                n_err++; $display("FAIL scan_an k=%0d got %h exp %h", k, an, exp_an);
            end
            n_cmp++;
            if (seg !== seg_tbl[slot]) begin
                n_err++; $display("FAIL scan_seg k=%0d got %h exp %h", k, seg, seg_tbl[slot]);
            end
        end
    endtask

    task automatic test_bright();
        int slot, ph, lows;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        lows = 0;
        restart_scan(32'h07);
        for (int k = 1; k <= 128; k++) begin
            @(negedge clk);
            slot = ((k - 1) / RD) % ND;
            ph = (k - 1) % RD;
            exp_an  = (ph <= 3) ? ~(8'h01 << slot) : 8'hFF;
            exp_seg = (ph <= 3) ? seg_tbl[slot] : 7'h7F;
            if (an !== 8'hFF) lows++;
            n_cmp++;
            if (an !== exp_an) begin
                n_err++; $display("FAIL bright_an k=%0d got %h exp %h", k, an, exp_an);
            end
            n_cmp++;
            if (seg !== exp_seg) begin
                n_err++; $display("FAIL bright_seg k=%0d got %h exp %h", k, seg, exp_seg);
            end
        end
        n_cmp++;
        if (lows != 32) begin
            n_err++; $display("FAIL bright_on_cycles got %0d exp 32", lows);
        end
    endtask

    task automatic test_blank();
        int slot;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        bus_write(4'd2, 32'h30);
        restart_scan(32'h1F);
        for (int k = 1; k <= 128; k++) begin
            @(negedge clk);
            slot = ((k - 1) / RD) % ND;
            exp_an  = (slot == 2) ? 8'hFF : ~(8'h01 << slot);
            exp_seg = (slot == 2) ? 7'h7F : seg_tbl[slot];
            n_cmp++;
            if (an !== exp_an) begin
                n_err++; $display("FAIL blank_an k=%0d got %h exp %h", k, an, exp_an);
            end
            n_cmp++;
            if (seg !== exp_seg) begin
                n_err++; $display("FAIL blank_seg k=%0d got %h exp %h", k, seg, exp_seg);
            end
        end
        bus_write(4'd2, 32'h1A);
        restart_scan(32'h1F);
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            slot = (k - 1) / RD;
            exp_seg = (slot == 2) ? 7'h08 : seg_tbl[slot];
            exp_dp  = (slot == 2) ? 1'b0 : 1'b1;
            n_cmp++;
            if (seg !== exp_seg) begin
                n_err++; $display("FAIL dp_seg k=%0d got %h exp %h", k, seg, exp_seg);
            end
            n_cmp++;
            if (dp !== exp_dp) begin
                n_err++; $display("FAIL dp_level k=%0d got %b exp %b", k, dp, exp_dp);
            end
        end
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] d;
        logic [31:0] e;
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b1; addr = 4'd5; wr_data = 32'h9;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        n_cmp++;
        if (rd_data !== 32'h5) begin
            n_err++; $display("FAIL rw_collide_old got %h exp %h", rd_data, 32'h5);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_data !== 32'h5) begin
            n_err++; $display("FAIL rd_hold got %h exp %h", rd_data, 32'h5);
        end
        exp_q.push_back(32'h9);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1F);
        exp_q.push_back(32'h3F);
        bus_read(4'd5, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_err++; $display("FAIL rw_new_value got %h exp %h", d, e);
        end
        bus_read(4'd9, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_err++; $display("FAIL unmapped_read got %h exp %h", d, e);
        end
        bus_write(4'd12, 32'hFFFF_FFFF);
        bus_read(CTRL_A, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_err++; $display("FAIL unmapped_write got %h exp %h", d, e);
        end
        bus_write(4'd1, 32'hFFFF_FFFF);
        bus_read(4'd1, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_err++; $display("FAIL digit_field_mask got %h exp %h", d, e);
        end
        bus_write(4'd1, 32'h1);
        bus_write(4'd5, 32'h5);
    endtask

    task automatic test_disable();
        restart_scan(32'h1F);
        repeat (70) @(negedge clk);
        n_cmp++;
        if (an !== 8'hEF) begin
            n_err++; $display("FAIL slot4_an got %h exp %h", an, 8'hEF);
        end
        n_cmp++;
        if (seg !== seg_tbl[4]) begin
            n_err++; $display("FAIL slot4_seg got %h exp %h", seg, seg_tbl[4]);
        end
        bus_write(CTRL_A, 32'h1E);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (an !== 8'hFF) begin
                n_err++; $display("FAIL disable_an k=%0d got %h exp %h", k, an, 8'hFF);
            end
            n_cmp++;
            if (seg !== 7'h7F) begin
                n_err++; $display("FAIL disable_seg k=%0d got %h exp %h", k, seg, 7'h7F);
            end
        end
        bus_write(CTRL_A, 32'h1F);
        n_cmp++;
        if (an !== 8'hFF) begin
            n_err++; $display("FAIL reenable_edge_an got %h exp %h", an, 8'hFF);
        end
        @(negedge clk);
        n_cmp++;
        if (an !== 8'hFE) begin
            n_err++; $display("FAIL reenable_first_an got %h exp %h", an, 8'hFE);
        end
        n_cmp++;
        if (seg !== seg_tbl[0]) begin
            n_err++; $display("FAIL reenable_first_seg got %h exp %h", seg, seg_tbl[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr = '0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_scan();
        test_bright();
        test_blank();
        test_rw_same_cycle();
        test_disable();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
